// File: rtl/fir_pkg.sv
// Shared definitions for the FIR frame datapath blocks: default widths, frame
// timing and the frame sequencer state encoding.
package fir_pkg;

  localparam int FIR_DW         = 8;
  localparam int FIR_RW         = 20;
  localparam int FIR_FRAME_LEN  = 32;
  localparam int FIR_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample buffer feeding the FIR frame sequencer.
// The head word is valid whenever empty is low.
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fir_frame_sequencer.sv
// Launches one FIR frame per buffered sample and collects at most one result
// per frame, flagging frames that end without a result.
module fir_frame_sequencer
  import fir_pkg::*;
#(
  parameter int DW         = FIR_DW,
  parameter int RW         = FIR_RW,
  parameter int FRAME_LEN  = FIR_FRAME_LEN,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          fir_in_st,
  output logic [DW-1:0] fir_din,
  input  logic          fir_out_st,
  input  logic [RW-1:0] fir_dout,
  output logic          m_valid,
  output logic [RW-1:0] m_data,
  input  logic          m_ready,
  output logic          err_timeout
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 2);

  seq_state_t                    state;
  logic [CW-1:0]                 frame_cnt;
  logic                          res_flag;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [DW-1:0]                 fifo_head;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_unused;
  logic                          launch;
  logic                          run_last;
  logic                          res_take;

  fir_sample_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s_valid),
    .push_data (s_data),
    .pop       (launch),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  // A held result blocks new frames, so m_data can never be overwritten.
  assign launch    = (state == ST_IDLE) && !fifo_empty && !m_valid;
  assign run_last  = (state == ST_RUN) && (frame_cnt == LAST_CNT);
  assign res_take  = (state == ST_RUN) && fir_out_st && !res_flag;
  assign s_ready   = !fifo_full;
  assign fir_in_st = (state == ST_START);

  // frame_cnt reads 0 in START and counts cycles since the start pulse, so
  // START + RUN + IDLE spans exactly FRAME_LEN cycles between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      res_flag    <= 1'b0;
      fir_din     <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state     <= ST_START;
            fir_din   <= fifo_head;
            frame_cnt <= '0;
          end
        end
        ST_START: begin
          state     <= ST_RUN;
          frame_cnt <= frame_cnt + 1'b1;
          res_flag  <= 1'b0;
        end
        ST_RUN: begin
          if (run_last) begin
            state       <= ST_IDLE;
            frame_cnt   <= '0;
            err_timeout <= !(res_flag || res_take);
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (res_take) begin
        res_flag <= 1'b1;
        m_valid  <= 1'b1;
        m_data   <= fir_dout;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Randomized bench for fir_frame_sequencer: a frame-timing reference model
// predicts every output each cycle, plus directed scenario summaries.
module tb_fir_frame_sequencer;

  localparam int DW         = 8;
  localparam int RW         = 20;
  localparam int FRAME_LEN  = 32;
  localparam int FIFO_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          fir_in_st;
  logic [DW-1:0] fir_din;
  logic          fir_out_st = 1'b0;
  logic [RW-1:0] fir_dout = '0;
  logic          m_valid;
  logic [RW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic          err_timeout;

  always #5 clk = ~clk;

  fir_frame_sequencer #(
    .DW         (DW),
    .RW         (RW),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .fir_in_st   (fir_in_st),
    .fir_din     (fir_din),
    .fir_out_st  (fir_out_st),
    .fir_dout    (fir_dout),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .err_timeout (err_timeout)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are tracked by the cycle of their start pulse.
  int            n = 0;
  int            last_start = -1000;
  bit            got = 1'b1;
  bit            mv = 1'b0;
  logic [RW-1:0] md = '0;
  logic [DW-1:0] din_exp = '0;
  logic [DW-1:0] sq[$];
  logic [DW-1:0] to_send[$];

  bit            p_sv = 1'b0, p_fo = 1'b0, p_mr = 1'b0;
  logic [DW-1:0] p_sd = '0;
  logic [RW-1:0] p_fd = '0;

  int            odelay = 1;
  bit            rand_delay = 1'b0;
  int            dout_mode = 0;
  logic [RW-1:0] dout_fix = '0;
  int            mr_pct = 100;
  bit            gaps = 1'b0;
  bit            spur = 1'b0;

  int            starts[$];
  int            errs[$];
  logic [RW-1:0] res[$];
  bit            sr_dropped;

  task automatic drive();
    p_sv = (to_send.size() > 0) && (!gaps || $urandom_range(2) != 0);
    p_sd = (to_send.size() > 0) ? to_send[0] : '0;
    p_fo = ((n - last_start) == odelay) || (spur && $urandom_range(15) == 0);
    case (dout_mode)
      1:       p_fd = RW'(din_exp);
      2:       p_fd = dout_fix;
      default: p_fd = RW'($urandom);
    endcase
    p_mr       = ($urandom_range(99) < mr_pct);
    s_valid    = p_sv;
    s_data     = p_sd;
    fir_out_st = p_fo;
    fir_dout   = p_fd;
    m_ready    = p_mr;
  endtask

  task automatic step();
    bit            start_e, run_prev, err_e, acc, push_ok;
    logic [DW-1:0] tmp;
    @(posedge clk);
    #1;
    n++;
    start_e  = ((n - 1) >= last_start + FRAME_LEN - 1) && (sq.size() > 0) && !mv;
    run_prev = ((n - 1) >= last_start + 1) && ((n - 1) <= last_start + FRAME_LEN - 2);
    push_ok  = p_sv && (sq.size() < FIFO_DEPTH);
    if (start_e) din_exp = sq.pop_front();
    if (push_ok) begin
      sq.push_back(p_sd);
      tmp = to_send.pop_front();
    end
    acc = p_fo && run_prev && !got;
    if (mv && p_mr) res.push_back(md);
    if (acc) begin
      got = 1'b1;
      mv  = 1'b1;
      md  = p_fd;
    end else if (mv && p_mr) begin
      mv = 1'b0;
    end
    err_e = ((n - 1) == last_start + FRAME_LEN - 2) && !got;
    if (start_e) begin
      last_start = n;
      got        = 1'b0;
      starts.push_back(n);
      if (rand_delay) odelay = $urandom_range(1, 40);
    end
    if (err_e) errs.push_back(n);

    chk("fir_in_st",   32'(fir_in_st),   32'(start_e));
    chk("fir_din",     32'(fir_din),     32'(din_exp));
    chk("s_ready",     32'(s_ready),     32'(sq.size() < FIFO_DEPTH));
    chk("m_valid",     32'(m_valid),     32'(mv));
    chk("m_data",      32'(m_data),      32'(md));
    chk("err_timeout", 32'(err_timeout), 32'(err_e));
    if (!s_ready) sr_dropped = 1'b1;
    drive();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},     32'(s_ready),     32'd1);
    chk({tag, "_fir_in_st"},   32'(fir_in_st),   32'd0);
    chk({tag, "_fir_din"},     32'(fir_din),     32'd0);
    chk({tag, "_m_valid"},     32'(m_valid),     32'd0);
    chk({tag, "_m_data"},      32'(m_data),      32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_async");
    sq.delete();
    to_send.delete();
    last_start = -1000;
    got        = 1'b1;
    mv         = 1'b0;
    md         = '0;
    din_exp    = '0;
    p_sv = 1'b0; p_fo = 1'b0; p_mr = 1'b0;
    s_valid = 1'b0; fir_out_st = 1'b0; m_ready = 1'b0;
    @(posedge clk);
    #1;
    n++;
    chk_reset_vals("rst_hold");
    rst = 1'b1;
    drive();
  endtask

  task automatic begin_scn();
    starts.delete();
    errs.delete();
    res.delete();
    sr_dropped = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Single sample, result at cycle 18 of the frame.
    begin_scn();
    odelay = 18; dout_mode = 2; dout_fix = 20'h00ABC; mr_pct = 100;
    to_send.push_back(8'h5A);
    repeat (45) step();
    chk("s1_starts", 32'(starts.size()), 32'd1);
    chk("s1_res_n",  32'(res.size()),    32'd1);
    chk("s1_res",    res.size() > 0 ? 32'(res[0]) : 32'hDEADBEEF, 32'h00ABC);

    // Back-to-back samples: exact frame spacing and in-order results.
    begin_scn();
    odelay = 10; dout_mode = 1;
    for (int i = 1; i <= 4; i++) to_send.push_back(DW'(i));
    repeat (150) step();
    chk("s2_starts", 32'(starts.size()), 32'd4);
    for (int i = 1; i < 4; i++)
      chk("s2_gap", starts.size() > i ? 32'(starts[i] - starts[i-1]) : 32'hDEADBEEF, 32'd32);
    for (int i = 0; i < 4; i++)
      chk("s2_res", res.size() > i ? 32'(res[i]) : 32'hDEADBEEF, 32'(i + 1));
    chk("s2_sready_high", 32'(sr_dropped), 32'd0);

    // Downstream stalled while six more samples arrive.
    begin_scn();
    odelay = 5; mr_pct = 0;
    to_send.push_back(8'h70);
    repeat (40) step();
    for (int i = 1; i <= 6; i++) to_send.push_back(DW'(8'h70 + i));
    repeat (12) step();
    chk("s3_sready_low", 32'(s_ready),         32'd0);
    chk("s3_pending",    32'(to_send.size()),  32'd2);
    chk("s3_one_start",  32'(starts.size()),   32'd1);
    mr_pct = 100;
    repeat (260) step();
    chk("s3_res_n", 32'(res.size()), 32'd7);
    for (int i = 0; i < 7; i++)
      chk("s3_res", res.size() > i ? 32'(res[i]) : 32'hDEADBEEF, 32'(8'h70 + i));

    // Frame with no result, then a normal frame.
    begin_scn();
    odelay = 99;
    to_send.push_back(8'h33);
    repeat (40) step();
    chk("s4_err_n",   32'(errs.size()), 32'd1);
    chk("s4_err_lat", (errs.size() > 0 && starts.size() > 0) ? 32'(errs[0] - starts[0]) : 32'hDEADBEEF, 32'd31);
    chk("s4_no_res",  32'(res.size()),  32'd0);
    odelay = 7;
    to_send.push_back(8'h34);
    repeat (40) step();
    chk("s4_restart", 32'(starts.size()), 32'd2);
    chk("s4_res", res.size() > 0 ? 32'(res[0]) : 32'hDEADBEEF, 32'h34);

    // Long downstream stall holds the result and blocks the next frame.
    begin_scn();
    odelay = 3; mr_pct = 0;
    to_send.push_back(8'h41);
    to_send.push_back(8'h42);
    repeat (100) step();
    chk("s5_blocked", 32'(starts.size()), 32'd1);
    chk("s5_held",    32'(m_data),        32'h41);
    mr_pct = 100;
    repeat (70) step();
    chk("s5_starts", 32'(starts.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      chk("s5_res", res.size() > i ? 32'(res[i]) : 32'hDEADBEEF, 32'(8'h41 + i));

    // Reset in the middle of a frame.
    begin_scn();
    odelay = 20;
    to_send.push_back(8'h55);
    for (int k = 0; k < 20 && !(starts.size() > 0 && n == last_start + 10); k++) step();
    chk("s6_run10", starts.size() > 0 ? 32'(n - last_start) : 32'hDEADBEEF, 32'd10);
    do_reset();
    begin_scn();
    repeat (50) step();
    chk("s6_no_err", 32'(errs.size()), 32'd0);
    chk("s6_no_res", 32'(res.size()),  32'd0);

    // Randomized traffic with spurious and late FIR pulses.
    begin_scn();
    gaps = 1'b1; spur = 1'b1; rand_delay = 1'b1; dout_mode = 0; mr_pct = 60;
    odelay = $urandom_range(1, 40);
    for (int i = 0; i < 30; i++) to_send.push_back(DW'($urandom));
    repeat (1500) step();
    chk("rnd_drained", 32'(to_send.size() + sq.size()), 32'd0);
    chk("rnd_frames",  32'(starts.size()), 32'd30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_frame_sequencer.md
FIR_FRAME_SEQUENCER -- requirements
Module: fir_frame_sequencer

Interface
REQ-001 Parameter DW, 8, input sample width in bits.
REQ-002 Parameter RW, 20, FIR result width in bits.
REQ-003 Parameter FRAME_LEN, 32, FIR frame length in cycles; the minimum spacing between start pulses.
REQ-004 Parameter FIFO_DEPTH, 4, sample buffer depth (power of two).
REQ-005 clk  input  1  clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream sample valid.
REQ-008 s_data  input  DW  upstream sample.
REQ-009 s_ready  output  1  sample accepted when s_valid&&s_ready; equals FIFO not full.
REQ-010 fir_in_st  output  1  one-cycle frame start pulse to the FIR counter.
REQ-011 fir_din  output  DW  sample presented to the FIR; stable from the start pulse until the frame ends.
REQ-012 fir_out_st  input  1  FIR result-ready pulse.
REQ-013 fir_dout  input  RW  FIR result; sampled only in the cycle fir_out_st=1.
REQ-014 m_valid  output  1  result valid to downstream.
REQ-015 m_data  output  RW  result to downstream.
REQ-016 m_ready  input  1  downstream accept.
REQ-017 err_timeout  output  1  one-cycle pulse; the frame ended with no fir_out_st.

Function
REQ-018 FSM states: IDLE, START, RUN.
REQ-019 IDLE->START when the FIFO is non-empty and m_valid=0; the FIFO pops in the same cycle, loading fir_din.
REQ-020 START lasts exactly one cycle; fir_in_st=1 only in START; frame_cnt clears to 0; next state RUN.
REQ-021 RUN: frame_cnt increments by 1 per cycle; at frame_cnt==FRAME_LEN-2, next state IDLE. Two consecutive fir_in_st pulses are therefore at least FRAME_LEN cycles apart.
REQ-022 A fir_out_st in RUN, when the result flag is clear, sets the result flag.
REQ-023 In the same cycle, that fir_out_st loads fir_dout into m_data and sets m_valid on the next edge.
REQ-024 fir_out_st outside RUN, or a second fir_out_st in the same frame, is ignored; m_data and m_valid do not change.
REQ-025 On leaving RUN with the result flag clear, err_timeout pulses for one cycle and no result is produced.
REQ-026 m_valid stays high until m_valid&&m_ready; it then clears on the next edge. m_data is stable while m_valid=1.
REQ-027 A new frame does not start while m_valid=1. Results are therefore never overwritten and need no overflow handling.
REQ-028 FIFO push and pop in the same cycle is legal and leaves the count unchanged.
REQ-029 Push is blocked when full (s_ready=0); pop occurs only on the IDLE->START transition.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
REQ-031 frame_cnt width is log2(FRAME_LEN) bits and cannot wrap, because RUN exits first.

Reset
REQ-032 rst low asynchronously forces: state IDLE; FIFO empty; s_ready=1; fir_in_st=0; fir_din=0; frame_cnt=0; result flag=0; m_valid=0; m_data=0; err_timeout=0.
REQ-033 Reset mid-frame abandons the frame: no result and no err_timeout is emitted. Buffered samples are discarded.
REQ-034 After rst deasserts, the first start occurs no earlier than the second rising edge.

Structure
REQ-035 The shared package fir_pkg holds the FSM state enum and the FRAME_LEN and FIFO_DEPTH defaults.
REQ-036 The package also holds the DW and RW defaults, which the FIR datapath blocks share.
REQ-037 The sample buffer is one sub-module, fir_sample_fifo: synchronous, first-word-fall-through, with push/pop/full/empty/count.
REQ-038 The FSM, frame counter and result register live in fir_frame_sequencer.

Verification
REQ-039 Single sample 8'h5A with m_ready=1 and fir_out_st at RUN cycle 18 (fir_dout=20'h00ABC):
- fir_in_st pulses once, with fir_din=8'h5A;
- m_valid=1 with m_data=20'h00ABC one cycle later;
- m_valid clears the following cycle.
REQ-040 Four back-to-back samples 1,2,3,4 with m_ready=1:
- s_ready stays high;
- consecutive fir_in_st pulses are exactly 32 cycles apart;
- results emerge in order 1,2,3,4.
REQ-041 Six samples pushed while the FIR is stalled:
- s_ready drops after the 4th sample is buffered (one more is in flight);
- no sample is lost or duplicated.
REQ-042 A frame with no fir_out_st:
- err_timeout pulses once, 31 cycles after fir_in_st;
- m_valid stays 0;
- the next frame starts normally.
REQ-043 m_ready=0 held for 100 cycles after the first result:
- m_data is held;
- no second fir_in_st occurs until the m_ready handshake completes.
REQ-044 rst asserted at RUN cycle 10:
- all outputs reach their reset values immediately;
- no err_timeout pulses and no m_valid is asserted afterward.
